// File: rtl/ctrl_pkg.sv
// Shared constants and control-word layout for the ID-stage decoder.
// The packed struct order matches the bit layout of ctrl_o exactly.
package ctrl_pkg;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_L     = 5'b00000;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4, ALU_OR  = 4'd5, ALU_AND = 4'd6, ALU_SRL  = 4'd7,
    ALU_SLL  = 4'd8, ALU_SRA = 4'd9
  } alu_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_UI = 3'd1, IMM_LI = 3'd2, IMM_SH5 = 3'd3,
    IMM_BR   = 3'd4, IMM_ST = 3'd5, IMM_JP = 3'd6
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2
  } mem_ctr_e;

  // Memsel carries the RV32I load/store width encoding (funct3).
  localparam logic [2:0] MSEL_B  = 3'b000;
  localparam logic [2:0] MSEL_H  = 3'b001;
  localparam logic [2:0] MSEL_W  = 3'b010;
  localparam logic [2:0] MSEL_BU = 3'b100;
  localparam logic [2:0] MSEL_HU = 3'b101;

  localparam int CTRL_JUMP   = 23;
  localparam int CTRL_BRCOND = 20;
  localparam int CTRL_BRUN   = 19;
  localparam int CTRL_BRANCH = 18;
  localparam int CTRL_IMM    = 15;
  localparam int CTRL_REGWEN = 14;
  localparam int CTRL_ASEL   = 13;
  localparam int CTRL_BSEL   = 12;
  localparam int CTRL_ALU    = 8;
  localparam int CTRL_MEMCTR = 6;
  localparam int CTRL_MEMRW  = 5;
  localparam int CTRL_MEMSEL = 2;
  localparam int CTRL_WB     = 0;

  typedef struct packed {
    logic       is_jump;
    logic [2:0] br_cond;
    logic       br_un;
    logic       is_branch;
    imm_sel_e   imm_sel;
    logic       reg_wen;
    logic       a_sel;
    logic       b_sel;
    alu_sel_e   alu_sel;
    mem_ctr_e   mem_ctr;
    logic       mem_rw;
    logic [2:0] mem_sel;
    wb_sel_e    wb_sel;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_lut.sv
// Combinational RV32I decode: instruction word to control word, illegal
// flag, and which source registers the instruction actually reads.
module ctrl_decode_lut
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  ctrl_t      dec;
  logic       bad;
  logic       use1;
  logic       use2;

  assign opcode   = instr[6:2];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  always_comb begin
    dec  = '0;
    bad  = 1'b0;
    use1 = 1'b0;
    use2 = 1'b0;
    case (opcode)
      OP_R: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_ALU;
        case (funct3)
          3'b000:  dec.alu_sel = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_sel = ALU_SLL;
          3'b010:  dec.alu_sel = ALU_SLT;
          3'b011:  dec.alu_sel = ALU_SLTU;
          3'b100:  dec.alu_sel = ALU_XOR;
          3'b101:  dec.alu_sel = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_sel = ALU_OR;
          default: dec.alu_sel = ALU_AND;
        endcase
        if (funct7b5 && funct3 != 3'b000 && funct3 != 3'b101) bad = 1'b1;
      end
      OP_I: begin
        use1 = 1'b1;
        dec.reg_wen = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_LI;
        dec.wb_sel  = WB_ALU;
        case (funct3)
          3'b000: dec.alu_sel = ALU_ADD;
          3'b001: begin
            dec.alu_sel = ALU_SLL;
            dec.imm_sel = IMM_SH5;
            bad = funct7b5;
          end
          3'b010: dec.alu_sel = ALU_SLT;
          3'b011: dec.alu_sel = ALU_SLTU;
          3'b100: dec.alu_sel = ALU_XOR;
          3'b101: begin
            dec.alu_sel = funct7b5 ? ALU_SRA : ALU_SRL;
            dec.imm_sel = IMM_SH5;
          end
          3'b110:  dec.alu_sel = ALU_OR;
          default: dec.alu_sel = ALU_AND;
        endcase
      end
      OP_L: begin
        use1 = 1'b1;
        dec.reg_wen = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_LI;
        dec.mem_ctr = MEM_LOAD;
        dec.mem_sel = funct3;
        dec.wb_sel  = WB_MEM;
        bad = !(funct3 == MSEL_B || funct3 == MSEL_H || funct3 == MSEL_W ||
                funct3 == MSEL_BU || funct3 == MSEL_HU);
      end
      OP_S: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_ST;
        dec.mem_ctr = MEM_STORE;
        dec.mem_rw  = 1'b1;
        dec.mem_sel = funct3;
        bad = !(funct3 == MSEL_B || funct3 == MSEL_H || funct3 == MSEL_W);
      end
      OP_B: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dec.is_branch = 1'b1;
        dec.br_cond   = funct3;
        dec.br_un     = funct3[2] & funct3[1];
        dec.imm_sel   = IMM_BR;
        dec.a_sel     = 1'b1;
        dec.b_sel     = 1'b1;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.is_jump = 1'b1;
        dec.imm_sel = IMM_JP;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        use1 = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm_sel = IMM_LI;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_PC4;
        bad = (funct3 != 3'b000);
      end
      // LUI leaves Asel at rs1; EX forces operand A to zero for Immsel=UI, Asel=0.
      OP_LUI: begin
        dec.imm_sel = IMM_UI;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_ALU;
      end
      OP_AUIPC: begin
        dec.imm_sel = IMM_UI;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.reg_wen = 1'b1;
        dec.wb_sel  = WB_ALU;
      end
      default: bad = 1'b1;
    endcase
  end

  // Illegal encodings never read registers, so they cannot cause a stall.
  assign ctrl     = bad ? '0 : dec;
  assign illegal  = bad;
  assign rs1_used = use1 & ~bad;
  assign rs2_used = use2 & ~bad;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID stage: registers the decoded control word and register indices,
// with valid/ready handshakes, load-use bubbles and EX-driven flush.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CTRL_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              illegal_o
);

  localparam int CNT_W = 2;
  // The hazard cycle itself is the first bubble, so the counter covers the rest.
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);

  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              rs1_used;
  logic              rs2_used;
  logic [CNT_W-1:0]  stall_cnt;
  logic [REG_AW-1:0] rs1_f;
  logic [REG_AW-1:0] rs2_f;
  logic [REG_AW-1:0] rd_f;
  logic              load_out;
  logic              hazard;
  logic              advance;
  logic              accept;

  ctrl_decode_lut u_lut (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign rs1_f = instr[15 +: REG_AW];
  assign rs2_f = instr[20 +: REG_AW];
  assign rd_f  = instr[7 +: REG_AW];

  assign load_out = out_valid && (ctrl_o[CTRL_MEMCTR +: 2] == 2'(MEM_LOAD));
  assign hazard   = in_valid && out_ready && load_out && (rd_o != '0) &&
                    ((rs1_used && rd_o == rs1_f) || (rs2_used && rd_o == rs2_f));
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && (stall_cnt == '0) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_o    <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      rd_o      <= '0;
      illegal_o <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall_cnt != '0)
        stall_cnt <= stall_cnt - CNT_W'(1);
      else if (hazard)
        stall_cnt <= STALL_LOAD;
      if (advance) begin
        out_valid <= accept;
        if (accept) begin
          ctrl_o    <= CTRL_W'(dec_ctrl);
          rs1_o     <= rs1_f;
          rs2_o     <= rs2_f;
          rd_o      <= rd_f;
          illegal_o <= dec_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe with hand-computed control words,
// run with two load-use bubbles.
module tb_ctrl_decode_pipe;

  localparam int REG_AW = 5;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ANDI  = 32'h0070F193;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00528333;
  localparam logic [31:0] I_ADDI7 = 32'h00508393;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BLTU  = 32'h0020E463;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_BR010 = 32'h0020A463;
  localparam logic [31:0] I_JAL   = 32'h000000EF;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [23:0]       ctrl_o;
  logic [REG_AW-1:0] rs1_o;
  logic [REG_AW-1:0] rs2_o;
  logic [REG_AW-1:0] rd_o;
  logic              illegal_o;

  int tests;
  int failures;

  ctrl_decode_pipe #(.REG_AW(REG_AW), .STALL_CYCLES(2), .CTRL_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_o    (ctrl_o),
    .rs1_o     (rs1_o),
    .rs2_o     (rs2_o),
    .rd_o      (rd_o),
    .illegal_o (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] word,
                                input logic rdy, input logic fl);
    in_valid  = v;
    instr     = word;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check_output("rst_valid", 32'(out_valid), 32'h0);
    check_output("rst_ctrl", 32'(ctrl_o), 32'h0);
    check_output("rst_rs1", 32'(rs1_o), 32'h0);
    check_output("rst_rs2", 32'(rs2_o), 32'h0);
    check_output("rst_rd", 32'(rd_o), 32'h0);
    check_output("rst_illegal", 32'(illegal_o), 32'h0);
    rst = 1'b0;

    apply_stimulus(1'b1, I_ADD, 1'b1, 1'b0);
    #1 check_output("add_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_output("add_valid", 32'(out_valid), 32'h1);
    check_output("add_ctrl", 32'(ctrl_o), 32'h004001);
    check_output("add_rd", 32'(rd_o), 32'd3);
    check_output("add_rs1", 32'(rs1_o), 32'd1);
    check_output("add_rs2", 32'(rs2_o), 32'd2);
    check_output("add_illegal", 32'(illegal_o), 32'h0);

    apply_stimulus(1'b1, I_ANDI, 1'b1, 1'b0);
    tick();
    check_output("andi_ctrl", 32'(ctrl_o), 32'h015601);
    check_output("andi_illegal", 32'(illegal_o), 32'h0);
    check_output("andi_rd", 32'(rd_o), 32'd3);

    apply_stimulus(1'b1, I_LW, 1'b1, 1'b0);
    tick();
    check_output("lw_valid", 32'(out_valid), 32'h1);
    check_output("lw_ctrl", 32'(ctrl_o), 32'h015048);
    check_output("lw_rd", 32'(rd_o), 32'd5);
    apply_stimulus(1'b1, I_ADDI7, 1'b1, 1'b0);
    #1 check_output("addi_imm_not_rs2", 32'(in_ready), 32'h1);
    apply_stimulus(1'b1, I_ADD6, 1'b1, 1'b0);
    #1 check_output("hazard_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_output("bubble1_valid", 32'(out_valid), 32'h0);
    check_output("bubble1_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_output("bubble2_valid", 32'(out_valid), 32'h0);
    check_output("bubble2_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_output("dep_valid", 32'(out_valid), 32'h1);
    check_output("dep_ctrl", 32'(ctrl_o), 32'h004001);
    check_output("dep_rd", 32'(rd_o), 32'd6);
    check_output("dep_rs1", 32'(rs1_o), 32'd5);

    apply_stimulus(1'b1, I_BEQ, 1'b1, 1'b0);
    tick();
    check_output("beq_ctrl", 32'(ctrl_o), 32'h063000);
    check_output("beq_is_branch", 32'(ctrl_o[18]), 32'h1);
    check_output("beq_br_cond", 32'(ctrl_o[22:20]), 32'h0);
    check_output("beq_brun", 32'(ctrl_o[19]), 32'h0);
    check_output("beq_immsel", 32'(ctrl_o[17:15]), 32'd4);
    apply_stimulus(1'b1, I_BLTU, 1'b1, 1'b0);
    tick();
    check_output("bltu_ctrl", 32'(ctrl_o), 32'h6E3000);

    apply_stimulus(1'b1, I_ANDI, 1'b1, 1'b1);
    #1 check_output("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_output("flush_valid", 32'(out_valid), 32'h0);

    apply_stimulus(1'b1, I_ANDI, 1'b1, 1'b0);
    tick();
    check_output("andi2_valid", 32'(out_valid), 32'h1);
    apply_stimulus(1'b1, I_SW, 1'b0, 1'b0);
    #1 check_output("hold_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("hold_valid", 32'(out_valid), 32'h1);
      check_output("hold_ctrl", 32'(ctrl_o), 32'h015601);
      check_output("hold_rd", 32'(rd_o), 32'd3);
      check_output("hold_in_ready2", 32'(in_ready), 32'h0);
    end
    apply_stimulus(1'b1, I_SW, 1'b1, 1'b0);
    #1 check_output("release_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_output("sw_ctrl", 32'(ctrl_o), 32'h0290A8);
    check_output("sw_rs2", 32'(rs2_o), 32'd2);
    check_output("sw_valid", 32'(out_valid), 32'h1);
    apply_stimulus(1'b0, I_SW, 1'b1, 1'b0);
    tick();
    check_output("idle_bubble", 32'(out_valid), 32'h0);

    apply_stimulus(1'b1, I_ILL, 1'b1, 1'b0);
    tick();
    check_output("ill7f_valid", 32'(out_valid), 32'h1);
    check_output("ill7f_flag", 32'(illegal_o), 32'h1);
    check_output("ill7f_ctrl", 32'(ctrl_o), 32'h0);
    apply_stimulus(1'b1, I_BR010, 1'b1, 1'b0);
    tick();
    check_output("br010_flag", 32'(illegal_o), 32'h1);
    check_output("br010_ctrl", 32'(ctrl_o), 32'h0);
    apply_stimulus(1'b1, I_JAL, 1'b1, 1'b0);
    tick();
    check_output("jal_flag", 32'(illegal_o), 32'h0);
    check_output("jal_ctrl", 32'(ctrl_o), 32'h837002);
    check_output("jal_rd", 32'(rd_o), 32'd1);

    apply_stimulus(1'b1, I_LW, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, I_ADD6, 1'b1, 1'b1);
    #1 check_output("flush_hazard_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_output("flush_hazard_valid", 32'(out_valid), 32'h0);
    apply_stimulus(1'b1, I_ADD6, 1'b1, 1'b0);
    #1 check_output("no_stall_after_flush", 32'(in_ready), 32'h1);
    tick();
    check_output("post_flush_rd", 32'(rd_o), 32'd6);

    apply_stimulus(1'b1, I_LW, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, I_ADD6, 1'b1, 1'b0);
    tick();
    check_output("stall_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    tick();
    check_output("midrst_valid", 32'(out_valid), 32'h0);
    check_output("midrst_ctrl", 32'(ctrl_o), 32'h0);
    check_output("midrst_rd", 32'(rd_o), 32'h0);
    rst = 1'b0;
    #1 check_output("midrst_in_ready", 32'(in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
